// File: rtl/ws2812_chain_scheduler.sv
// Frame scheduler for a WS2812 daisy-chain: buffers one GRB word per LED and
// streams them to a bit serializer, then enforces the latch gap between frames.
module ws2812_chain_scheduler #(
    parameter int NUM_LEDS       = 8,
    parameter int RESET_CYCLES   = 2500,
    parameter int REFRESH_CYCLES = 2_500_000,
    localparam int AW            = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          commit,
    output logic          pix_valid,
    output logic [23:0]   pix_data,
    output logic          pix_last,
    input  logic          pix_ready,
    input  logic          ser_idle,
    output logic          busy,
    output logic          frame_done,
    output logic [1:0]    dbg_state
);

    // Handshake: a pixel moves when pix_valid && pix_ready at a rising edge;
    // while pix_valid is high and pix_ready low, pix_data/pix_last are held.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        LATCH  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_IDX     = AW'(NUM_LEDS - 1);
    localparam logic [AW:0]   NUM_LEDS_W   = (AW + 1)'(NUM_LEDS);
    localparam logic [31:0]   RESET_LAST   = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]   REFRESH_LAST = (REFRESH_CYCLES == 0) ? 32'd0 : 32'(REFRESH_CYCLES - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          pix_valid_q, pix_valid_d;
    logic [23:0]   pix_data_q, pix_data_d;
    logic          pix_last_q, pix_last_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          pending_q, pending_d;
    logic [31:0]   refresh_q, refresh_d;
    logic [31:0]   gap_q, gap_d;
    logic [23:0]   store_q [NUM_LEDS];
    logic [23:0]   store_d [NUM_LEDS];

    logic [AW-1:0] idx_next;
    logic          wr_in_range;
    logic          refresh_hit;
    logic          start;

    assign idx_next    = idx_q + AW'(1);
    assign wr_in_range = ({1'b0, wr_addr} < NUM_LEDS_W);
    assign refresh_hit = (REFRESH_CYCLES != 0) && (refresh_q == REFRESH_LAST);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pix_valid_d  = pix_valid_q;
        pix_data_d   = pix_data_q;
        pix_last_d   = pix_last_q;
        frame_done_d = 1'b0;
        pending_d    = pending_q;
        refresh_d    = refresh_q;
        gap_d        = gap_q;
        store_d      = store_q;
        start        = 1'b0;

        // Loads below read store_q, so a same-cycle write lands in the next frame.
        if (wr_en && wr_in_range) begin
            store_d[wr_addr] = wr_data;
        end

        case (state_q)
            IDLE: begin
                // The frame_done cycle is not a start slot: frames are separated
                // by at least one plain idle cycle.
                start = !frame_done_q && (pending_q || commit || refresh_hit);
                if (start) begin
                    idx_d       = '0;
                    pix_data_d  = store_q[0];
                    pix_valid_d = 1'b1;
                    pix_last_d  = (NUM_LEDS == 1);
                    state_d     = STREAM;
                end else if (refresh_q != REFRESH_LAST) begin
                    refresh_d = refresh_q + 32'd1;
                end
            end
            STREAM: begin
                if (pix_valid_q && pix_ready) begin
                    if (idx_q == LAST_IDX) begin
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                        state_d     = DRAIN;
                    end else begin
                        idx_d      = idx_next;
                        pix_data_d = store_q[idx_next];
                        pix_last_d = (idx_next == LAST_IDX);
                    end
                end
            end
            DRAIN: begin
                if (ser_idle) begin
                    gap_d   = '0;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (gap_q == RESET_LAST) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    refresh_d    = '0;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            pending_d = 1'b0;
        end else if (commit) begin
            pending_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            pix_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            refresh_q    <= '0;
            gap_q        <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            pix_last_q   <= pix_last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            refresh_q    <= refresh_d;
            gap_q        <= gap_d;
            store_q      <= store_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_last   = pix_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule
